// File: rtl/rom_4kx8.sv
// rom_4kx8: 4096 x 8 synchronous read-only lookup memory with fixed contents.
// Ten low locations hold constants; all others read zero. One-cycle registered read.
// Optional feature: define ROM_PARITY_EN to add a registered even-parity output.
module rom_4kx8 #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] direccion,
    output logic [DATA_W-1:0] data,
    output logic              valid
`ifdef ROM_PARITY_EN
    ,
    output logic              parity
`endif
);

    logic [DATA_W-1:0] rom_word;

    // Contents table; full-width decode. Unknown addresses fall to the zero default,
    // so the table itself can never be disturbed, only the word read out.
    always_comb begin
        rom_word = '0;
        case (direccion)
            ADDR_W'(0): rom_word = DATA_W'(8'h3C);
            ADDR_W'(1): rom_word = DATA_W'(8'hA1);
            ADDR_W'(2): rom_word = DATA_W'(8'h7F);
            ADDR_W'(3): rom_word = DATA_W'(8'h08);
            ADDR_W'(4): rom_word = DATA_W'(8'hC4);
            ADDR_W'(5): rom_word = DATA_W'(8'h55);
            ADDR_W'(6): rom_word = DATA_W'(8'hFF);
            ADDR_W'(7): rom_word = DATA_W'(8'h12);
            ADDR_W'(8): rom_word = DATA_W'(8'h90);
            ADDR_W'(9): rom_word = DATA_W'(8'h6E);
            default:    rom_word = '0;
        endcase
    end

    // Output register: load on enabled read, hold data otherwise; valid tracks en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                data <= rom_word;
            end
        end
    end

`ifdef ROM_PARITY_EN
    // Parity register, updated alongside data from the same stored word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (en) begin
            parity <= ^rom_word;
        end
    end
`endif

endmodule

// File: tb/tb_rom_4kx8.sv
// tb_rom_4kx8: directed self-checking bench for rom_4kx8.
// Parity checks compile in only when ROM_PARITY_EN is defined.
module tb_rom_4kx8;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] direccion;
    logic [7:0]  data;
    logic        valid;
`ifdef ROM_PARITY_EN
    logic        parity;
`endif

    int n_cmp;
    int n_bad;

    logic [7:0] exp_tab [0:13];

    rom_4kx8 #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .direccion (direccion),
        .data      (data),
        .valid     (valid)
`ifdef ROM_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a read at the negedge, then sample 1 time unit after the next posedge.
    task automatic do_read(input logic [11:0] a, input logic e);
        @(negedge clk);
        en        = e;
        direccion = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [7:0] d, input logic v);
        // unused helper intentionally avoided; comparisons are inline in each test
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00", data);
        end
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", valid);
        end
        // edges under reset, even with en high, must do nothing
        en        = 1'b1;
        direccion = 12'h001;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (data !== 8'h00 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_clocked: got %h/%b want 00/0", data, valid);
        end
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        do_read(12'h000, 1'b0);
        do_read(12'h000, 1'b0);
        n_cmp++;
        if (data !== 8'h00 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_idle: got %h/%b want 00/0", data, valid);
        end
    endtask

    task automatic test_sweep;
        for (int i = 0; i < 14; i++) begin
            do_read(12'(i), 1'b1);
            n_cmp++;
            if (data !== exp_tab[i] || valid !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep_%0d: got %h/%b want %h/1", i, data, valid, exp_tab[i]);
            end
`ifdef ROM_PARITY_EN
            n_cmp++;
            if (parity !== ^exp_tab[i]) begin
                n_bad++;
                $display("FAIL sweep_par_%0d: got %b want %b", i, parity, ^exp_tab[i]);
            end
`endif
        end
    endtask

    task automatic test_hold;
        do_read(12'h006, 1'b1);
        n_cmp++;
        if (data !== 8'hFF || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_read: got %h/%b want ff/1", data, valid);
        end
        do_read(12'h001, 1'b0);
        n_cmp++;
        if (data !== 8'hFF || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_idle: got %h/%b want ff/0", data, valid);
        end
`ifdef ROM_PARITY_EN
        n_cmp++;
        if (parity !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_par: got %b want 0", parity);
        end
`endif
    endtask

    task automatic test_boundary;
        logic [11:0] addrs [0:5];
        logic [7:0]  exps  [0:5];
        addrs = '{12'hFFF, 12'h000, 12'h009, 12'h00A, 12'h800, 12'h803};
        exps  = '{8'h00, 8'h3C, 8'h6E, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            do_read(addrs[i], 1'b1);
            n_cmp++;
            if (data !== exps[i] || valid !== 1'b1) begin
                n_bad++;
                $display("FAIL boundary_%h: got %h/%b want %h/1", addrs[i], data, valid, exps[i]);
            end
        end
    endtask

    task automatic test_async_reset;
        do_read(12'h001, 1'b1);
        do_read(12'h002, 1'b1);
        n_cmp++;
        if (data !== 8'h7F || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre: got %h/%b want 7f/1", data, valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (data !== 8'h00 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_now: got %h/%b want 00/0", data, valid);
        end
`ifdef ROM_PARITY_EN
        n_cmp++;
        if (parity !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_par: got %b want 0", parity);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        direccion = 12'h003;
        @(posedge clk);
        #1;
        n_cmp++;
        if (data !== 8'h08 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_resume: got %h/%b want 08/1", data, valid);
        end
        do_read(12'h004, 1'b1);
        n_cmp++;
        if (data !== 8'hC4 || valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_next: got %h/%b want c4/1", data, valid);
        end
    endtask

    task automatic test_x_addr;
        do_read(12'hxxx, 1'b1);
        n_cmp++;
        if (valid !== 1'b1) begin
            n_bad++;
            $display("FAIL xaddr_valid: got %b want 1", valid);
        end
        do_read(12'h001, 1'b1);
        n_cmp++;
        if (data !== 8'hA1) begin
            n_bad++;
            $display("FAIL xaddr_after: got %h want a1", data);
        end
    endtask

`ifdef ROM_PARITY_EN
    task automatic test_parity;
        logic [11:0] addrs [0:2];
        logic        exps  [0:2];
        addrs = '{12'h001, 12'h005, 12'h003};
        exps  = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_read(addrs[i], 1'b1);
            n_cmp++;
            if (parity !== exps[i]) begin
                n_bad++;
                $display("FAIL parity_%h: got %b want %b", addrs[i], parity, exps[i]);
            end
        end
    endtask
`endif

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b1;
        en        = 1'b0;
        direccion = 12'h000;
        exp_tab   = '{8'h3C, 8'hA1, 8'h7F, 8'h08, 8'hC4, 8'h55, 8'hFF,
                      8'h12, 8'h90, 8'h6E, 8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
        test_sweep();
        test_hold();
        test_boundary();
        test_async_reset();
        test_x_addr();
`ifdef ROM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
